sdpram_rd_arbiter: RTL and testbench

//  Round-robin arbiter that shares the read port (port B) of one simple dual-port RAM among
//  NUM_REQ read requesters. Issues at most one read per clock and keeps the requester ID of

---
 rtl/sdpram_pkg.sv | 12 +
 rtl/sdpram_tag_fifo.sv | 65 ++++++
 rtl/sdpram_rd_arbiter.sv | 142 ++++++++++++++
 tb/tb_sdpram_rd_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_pkg.sv
// Shared types and helpers for the SDPRAM read-port arbiter.
package sdpram_pkg;

  localparam int MAX_REQ = 16;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sdpram_tag_fifo.sv
// In-order FIFO of requester IDs for reads that are issued but not yet returned.
// A push and a pop in the same cycle are accepted even when the FIFO is full.
module sdpram_tag_fifo
  import sdpram_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  req_id_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/sdpram_rd_arbiter.sv
// Round-robin arbiter sharing the read port of a simple dual-port RAM, with in-order response routing.
// Define SDPRAM_RD_ARB_PERF_EN to add the stall_cnt performance counter output.
module sdpram_rd_arbiter
  import sdpram_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MEM_DEPTH       = 1024,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int ADDR_WIDTH      = addr_w(MEM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         addrb,
  output logic                          renb,
  input  logic [DATA_WIDTH-1:0]         doutb,
  input  logic                          dvalb,
  output logic                          err_orphan
`ifdef SDPRAM_RD_ARB_PERF_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  req_id_t                last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]  addrb_q;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   err_orphan_q, err_orphan_d;

  logic [2*NUM_REQ-1:0]   valid_dbl;
  logic                   pick_vld;
  int                     pick_off, pick_sum;
  logic                   issue_ok, grant_vld, pop_ok;
  req_id_t                grant_id;
  logic [ADDR_WIDTH-1:0]  addr_sel;

  req_id_t                tag_head;
  logic [CNT_W-1:0]       tag_cnt;
  logic                   tag_empty, tag_full;

  // A full tag FIFO still admits a read when a word returns in the same cycle.
  assign issue_ok = (int'(tag_cnt) < MAX_OUTSTANDING) || (tag_full && dvalb);
  assign pop_ok   = dvalb & ~tag_empty;

  // Rotate the request vector so bit 0 is the requester just after last_grant.
  always_comb begin
    valid_dbl = {req_valid, req_valid} >> (int'(last_grant_q) + 1);
    pick_vld  = 1'b0;
    pick_off  = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid_dbl[j]) begin
        pick_vld = 1'b1;
        pick_off = j;
      end
    end
    pick_sum = int'(last_grant_q) + 1 + pick_off;
    if (pick_sum >= NUM_REQ) pick_sum = pick_sum - NUM_REQ;
    grant_id  = req_id_t'(pick_sum);
    grant_vld = pick_vld & issue_ok & ~rst;
  end

  always_comb begin
    req_ready = '0;
    addr_sel  = addrb_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_id == req_id_t'(i)) begin
        req_ready[i] = 1'b1;
        addr_sel     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    last_grant_d = grant_vld ? grant_id : last_grant_q;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = pop_ok && (tag_head == req_id_t'(i));
    end
    rsp_data_d   = pop_ok ? doutb : rsp_data_q;
    err_orphan_d = err_orphan_q | (dvalb & tag_empty);
  end

  sdpram_tag_fifo #(
    .DEPTH   (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant_vld),
    .push_id (grant_id),
    .pop     (dvalb),
    .head    (tag_head),
    .count   (tag_cnt),
    .empty   (tag_empty),
    .full    (tag_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= req_id_t'(NUM_REQ - 1);
      addrb_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      addrb_q      <= addr_sel;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign renb       = grant_vld;
  assign addrb      = addr_sel;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err_orphan = err_orphan_q;

`ifdef SDPRAM_RD_ARB_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (|req_valid && !grant_vld && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sdpram_rd_arbiter.sv
// Directed bench for sdpram_rd_arbiter with a 1-cycle-latency RAM model (mem[a] = a ^ 32'hA5A5_0000).
module tb_sdpram_rd_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int ADDR_WIDTH = 10;
  localparam logic [NUM_REQ*ADDR_WIDTH-1:0] STD_ADDR = {10'h0C5, 10'h085, 10'h045, 10'h005};

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [31:0]                   rsp_data;
  logic [ADDR_WIDTH-1:0]         addrb;
  logic                          renb;
  logic [31:0]                   doutb = '0;
  logic                          dvalb = 1'b0;
  logic                          err_orphan;
`ifdef SDPRAM_RD_ARB_PERF_EN
  logic [15:0]                   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdpram_rd_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .DATA_WIDTH      (32),
    .MEM_DEPTH       (1024),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .addrb      (addrb),
    .renb       (renb),
    .doutb      (doutb),
    .dvalb      (dvalb),
    .err_orphan (err_orphan)
`ifdef SDPRAM_RD_ARB_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  function automatic logic [31:0] word(input logic [ADDR_WIDTH-1:0] a);
    return {22'd0, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] std_addr(input int i);
    return ADDR_WIDTH'(10'h005 + 10'h040 * i);
  endfunction

  // RAM model: in-order pending queue; stall holds returns, orphan_inj forces a stray word.
  logic [ADDR_WIDTH-1:0] pend [$];
  logic ram_stall  = 1'b0;
  logic orphan_inj = 1'b0;

  always @(posedge clk) begin
    if (renb) pend.push_back(addrb);
    if (orphan_inj) begin
      dvalb <= 1'b1;
      doutb <= 32'hDEAD_BEEF;
    end else if (!ram_stall && pend.size() > 0) begin
      dvalb <= 1'b1;
      doutb <= word(pend.pop_front());
    end else begin
      dvalb <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    ram_stall  = 1'b0;
    orphan_inj = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_ready", req_ready, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_rspd", rsp_data, 0);
    check("rst_renb", renb, 0);
    check("rst_addrb", addrb, 0);
    check("rst_orphan", err_orphan, 0);

    // Test 1: single requester 2, addr 0x010
    req_addr  = {10'h000, 10'h010, 10'h000, 10'h000};
    req_valid = 4'b0100;
    #1;
    check("t1_gnt", req_ready, 4'b0100);
    check("t1_renb", renb, 1);
    check("t1_addrb", addrb, 10'h010);
    tick();
    req_valid = '0;
    #1;
    check("t1_rspv_c1", rsp_valid, 0);
    check("t1_renb_c1", renb, 0);
    tick();
    check("t1_rspv_c2", rsp_valid, 4'b0100);
    check("t1_rspd_c2", rsp_data, 32'hA5A5_0010);
    tick();
    check("t1_rspv_c3", rsp_valid, 0);
    check("t1_rspd_hold", rsp_data, 32'hA5A5_0010);
    check("t1_addrb_hold", addrb, 10'h010);

    // Test 2: all requesters valid continuously
    do_reset();
    req_addr  = STD_ADDR;
    req_valid = 4'hF;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        tick();
        #1;
      end
      check("t2_gnt", req_ready, 32'd1 << (c % 4));
      check("t2_addrb", addrb, std_addr(c % 4));
      if (c >= 2) begin
        check("t2_rspv", rsp_valid, 32'd1 << ((c - 2) % 4));
        check("t2_rspd", rsp_data, word(std_addr((c - 2) % 4)));
      end
    end
    req_valid = '0;
    repeat (4) tick();

    // Test 3: RAM stalled, outstanding limit and pop+push when full
    do_reset();
    req_addr  = STD_ADDR;
    ram_stall = 1'b1;
    req_valid = 4'hF;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        tick();
        #1;
      end
      check("t3_gnt", req_ready, 32'd1 << c);
    end
    tick();
    check("t3_blk_c4", req_ready, 0);
    check("t3_renb_c4", renb, 0);
    tick();
    check("t3_blk_c5", req_ready, 0);
    ram_stall = 1'b0;
    tick();
    ram_stall = 1'b1;
    check("t3_gnt5", req_ready, 4'b0001);
    check("t3_renb5", renb, 1);
    check("t3_addrb5", addrb, 10'h005);
    tick();
    check("t3_blk_c7", req_ready, 0);
    check("t3_rspv_c7", rsp_valid, 4'b0001);
    check("t3_rspd_c7", rsp_data, word(10'h005));
    req_valid = '0;
    ram_stall = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      check("t3_drain_v", rsp_valid, 32'd1 << ((j + 1) % 4));
      check("t3_drain_d", rsp_data, word(std_addr((j + 1) % 4)));
    end
    check("t3_orphan", err_orphan, 0);

    // Test 4: orphan return with nothing issued
    do_reset();
    orphan_inj = 1'b1;
    tick();
    orphan_inj = 1'b0;
    check("t4_orphan_c1", err_orphan, 0);
    tick();
    check("t4_orphan_c2", err_orphan, 1);
    check("t4_rspv_c2", rsp_valid, 0);
    repeat (3) tick();
    check("t4_sticky", err_orphan, 1);
    do_reset();
    check("t4_cleared", err_orphan, 0);

    // Test 5: reset with two reads in flight
    req_addr  = STD_ADDR;
    ram_stall = 1'b1;
    req_valid = 4'b0011;
    #1;
    check("t5_gnt0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    #1;
    check("t5_gnt1", req_ready, 4'b0010);
    tick();
    rst       = 1'b1;
    req_valid = 4'b1001;
    #1;
    check("t5_rst_ready", req_ready, 0);
    check("t5_rst_renb", renb, 0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    ram_stall = 1'b0;
    #1;
    check("t5_orphan_c3", err_orphan, 0);
    tick();
    check("t5_rspv_c4", rsp_valid, 0);
    tick();
    check("t5_orphan_c5", err_orphan, 1);
    check("t5_rspv_c5", rsp_valid, 0);
    tick();
    check("t5_rspv_c6", rsp_valid, 0);
    check("t5_orphan_c6", err_orphan, 1);
    req_valid = 4'b1001;
    #1;
    check("t5_gnt_after", req_ready, 4'b0001);
    check("t5_addrb_after", addrb, 10'h005);
    req_valid = '0;
    repeat (4) tick();

`ifdef SDPRAM_RD_ARB_PERF_EN
    // Test 6: stall counter and saturation
    do_reset();
    req_addr  = STD_ADDR;
    ram_stall = 1'b1;
    req_valid = 4'hF;
    repeat (4) tick();
    check("t6_stall0", stall_cnt, 0);
    req_valid = 4'b0010;
    repeat (3) tick();
    req_valid = '0;
    #1;
    check("t6_stall3", stall_cnt, 3);
    req_valid = 4'b0010;
    repeat (65540) tick();
    check("t6_sat", stall_cnt, 16'hFFFF);
    req_valid = '0;
    do_reset();
    check("t6_rst", stall_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
